// File: rtl/mdu_sched.sv
// HI/LO multiply-divide scheduler; defining MDU_CANCEL_EN lets cancel abort a running op.
// Latency MULT_CYCLES/DIV_CYCLES busy cycles after start; backpressure via stall on D_md while busy.
module mdu_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        cancel,
    input  logic        D_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] rdata
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   shi_q, shi_d, slo_q, slo_d;

    logic          is_calc, is_div, is_mt, start;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   divisor, quo_s, rem_s, quo_u, rem_u;

    assign is_calc = (E_MDUOp >= 4'd1) && (E_MDUOp <= 4'd4);
    assign is_div  = (E_MDUOp == 4'd3) || (E_MDUOp == 4'd4);
    assign is_mt   = (E_MDUOp == 4'd7) || (E_MDUOp == 4'd8);
    // Reset gating keeps stall low while reset is held even if an op is presented.
    assign start   = is_calc && !cancel && (state_q == IDLE) && !reset;

    assign busy    = (state_q == RUN);
    assign stall   = D_md && (start || busy);
    assign HI      = hi_q;
    assign LO      = lo_q;

    // Divisor forced nonzero so the divider never sees x/0; the zero case is handled below.
    assign divisor = (E_B == 32'd0) ? 32'd1 : E_B;
    assign prod_s  = 64'($signed(E_A)) * 64'($signed(E_B));
    assign prod_u  = {32'd0, E_A} * {32'd0, E_B};
    assign quo_s   = $signed(E_A) / $signed(divisor);
    assign rem_s   = $signed(E_A) % $signed(divisor);
    assign quo_u   = E_A / divisor;
    assign rem_u   = E_A % divisor;

    always_comb begin
        rdata = 32'd0;
        case (E_MDUOp)
            4'd5:    rdata = hi_q;
            4'd6:    rdata = lo_q;
            default: rdata = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        shi_d   = shi_q;
        slo_d   = slo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    case (E_MDUOp)
                        4'd1:    {shi_d, slo_d} = prod_s;
                        4'd2:    {shi_d, slo_d} = prod_u;
                        4'd3:    {shi_d, slo_d} = (E_B == 32'd0) ? {hi_q, lo_q} : {rem_s, quo_s};
                        default: {shi_d, slo_d} = (E_B == 32'd0) ? {hi_q, lo_q} : {rem_u, quo_u};
                    endcase
                end else if (is_mt && !cancel) begin
                    if (E_MDUOp == 4'd7) hi_d = E_A;
                    else                 lo_d = E_A;
                end
            end
            default: begin
`ifdef MDU_CANCEL_EN
                if (cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else
`endif
                begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        hi_d    = shi_q;
                        lo_d    = slo_q;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            shi_q   <= 32'd0;
            slo_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            shi_q   <= shi_d;
            slo_q   <= slo_d;
        end
    end
endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: cycle-level model comparison plus hand-computed literal checks.
module tb_mdu_sched;
    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MDU_CANCEL_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  E_MDUOp = 4'd0;
    logic [31:0] E_A = 32'd0, E_B = 32'd0;
    logic        cancel = 1'b0, D_md = 1'b0;
    logic        busy, stall;
    logic [31:0] HI, LO, rdata;

    int errors = 0;
    int checks = 0;

    mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .E_MDUOp(E_MDUOp), .E_A(E_A), .E_B(E_B),
        .cancel(cancel), .D_md(D_md), .busy(busy), .stall(stall),
        .HI(HI), .LO(LO), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: architectural HI/LO, remaining busy cycles, and the pending result.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    int          m_rem = 0;
    longint      sa, sb, ma, mb, q, r;
    logic [63:0] pu;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_rem = 0;
        end else if (m_rem > 0) begin
            if (CANCEL_EN && cancel) m_rem = 0;
            else begin
                m_rem--;
                if (m_rem == 0) begin m_hi = p_hi; m_lo = p_lo; end
            end
        end else if (!cancel) begin
            sa = longint'($signed(E_A));
            sb = longint'($signed(E_B));
            case (E_MDUOp)
                4'd1: begin pu = 64'(sa * sb); {p_hi, p_lo} = pu; m_rem = MC; end
                4'd2: begin pu = {32'd0, E_A} * {32'd0, E_B}; {p_hi, p_lo} = pu; m_rem = MC; end
                4'd3: begin
                    m_rem = DC;
                    if (E_B == 0) begin p_hi = m_hi; p_lo = m_lo; end
                    else begin
                        ma = (sa < 0) ? -sa : sa;
                        mb = (sb < 0) ? -sb : sb;
                        q  = ma / mb;
                        if ((sa < 0) != (sb < 0)) q = -q;
                        r  = sa - q * sb;
                        p_lo = q[31:0]; p_hi = r[31:0];
                    end
                end
                4'd4: begin
                    m_rem = DC;
                    if (E_B == 0) begin p_hi = m_hi; p_lo = m_lo; end
                    else begin p_lo = E_A / E_B; p_hi = E_A % E_B; end
                end
                4'd7: m_hi = E_A;
                4'd8: m_lo = E_A;
                default: ;
            endcase
        end
    end

    // Per-cycle compare against the model, plus the no-op-while-busy guard.
    always @(negedge clk) begin
        logic exp_start;
        exp_start = !reset && m_rem == 0 && E_MDUOp >= 1 && E_MDUOp <= 4 && !cancel;
        chk("busy", 32'(busy), 32'(m_rem > 0));
        chk("stall", 32'(stall), 32'(D_md && (exp_start || m_rem > 0)));
        chk("HI", HI, m_hi);
        chk("LO", LO, m_lo);
        chk("rdata", rdata, (E_MDUOp == 5) ? m_hi : (E_MDUOp == 6) ? m_lo : 32'd0);
        if (busy && ((E_MDUOp >= 1 && E_MDUOp <= 4) || E_MDUOp == 7 || E_MDUOp == 8)) begin
            errors++;
            $display("FAIL op_while_busy: op %0d presented while busy=1", E_MDUOp);
        end
    end

    task automatic tick(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic d);
        E_MDUOp = op; E_A = a; E_B = b; cancel = c; D_md = d;
        @(posedge clk); #2;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            n++;
            tick(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    vec_t vecs[6] = '{
        '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
        '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
        '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
        '{4'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003},
        '{4'd4, 32'd100,      32'd7,        32'd2,        32'd14},
        '{4'd3, 32'h80000000, 32'd2,        32'h00000000, 32'hC0000000}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset: outputs quiet even with an op and D_md presented.
        E_MDUOp = 4'd1; D_md = 1'b1; E_A = 32'd3; E_B = 32'd4;
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        E_MDUOp = 4'd6; #1;
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        tick(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        // mult -3 * 7 = -21
        tick(4'd1, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
        count_busy(n);
        chk("mult_busy_cycles", 32'(n), 32'd5);
        chk("mult_HI", HI, 32'hFFFFFFFF);
        chk("mult_LO", LO, 32'hFFFFFFEB);
        E_MDUOp = 4'd6; #1;
        chk("mflo_rdata", rdata, 32'hFFFFFFEB);
        E_MDUOp = 4'd5; #1;
        chk("mfhi_rdata", rdata, 32'hFFFFFFFF);
        @(posedge clk); #2;

        // div -7 / 2 -> q=-3, r=-1
        tick(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        count_busy(n);
        chk("div_busy_cycles", 32'(n), 32'd10);
        chk("div_LO", LO, 32'hFFFFFFFD);
        chk("div_HI", HI, 32'hFFFFFFFF);

        // divu by zero leaves HI/LO alone but still takes the full time
        tick(4'd4, 32'd7, 32'd0, 1'b0, 1'b0);
        count_busy(n);
        chk("div0_busy_cycles", 32'(n), 32'd10);
        chk("div0_HI", HI, 32'hFFFFFFFF);
        chk("div0_LO", LO, 32'hFFFFFFFD);

        // multu with D_md held: stall on start cycle and every busy cycle
        E_MDUOp = 4'd2; E_A = 32'hFFFFFFFF; E_B = 32'd2; D_md = 1'b1; #1;
        chk("multu_stall_start", 32'(stall), 32'd1);
        @(posedge clk); #2;
        for (int i = 0; i < MC; i++) begin
            E_MDUOp = 4'd0; #1;
            chk("multu_stall_busy", 32'(stall), 32'd1);
            @(posedge clk); #2;
        end
        #1;
        chk("multu_stall_after", 32'(stall), 32'd0);
        chk("multu_HI", HI, 32'd1);
        chk("multu_LO", LO, 32'hFFFFFFFE);

        // mthi: cancelled write is dropped, uncancelled write lands
        tick(4'd7, 32'h12345678, 32'd0, 1'b1, 1'b0);
        chk("mthi_cancel_HI", HI, 32'd1);
        tick(4'd7, 32'h12345678, 32'd0, 1'b0, 1'b0);
        chk("mthi_HI", HI, 32'h12345678);
        tick(4'd8, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0);
        chk("mtlo_LO", LO, 32'hCAFEF00D);
        // Cancelled calc must not start.
        tick(4'd1, 32'd2, 32'd2, 1'b1, 1'b0);
        chk("calc_cancel_busy", 32'(busy), 32'd0);

        // Directed operand table
        foreach (vecs[k]) begin
            tick(vecs[k].op, vecs[k].a, vecs[k].b, 1'b0, 1'b0);
            count_busy(n);
            chk("tbl_busy_cycles", 32'(n), (vecs[k].op <= 4'd2) ? 32'd5 : 32'd10);
            chk("tbl_HI", HI, vecs[k].hi);
            chk("tbl_LO", LO, vecs[k].lo);
        end
        tick(4'd7, 32'h12345678, 32'd0, 1'b0, 1'b0);
        tick(4'd8, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0);

        // cancel while a mult is at cnt=3
        tick(4'd1, 32'h00010000, 32'h00010000, 1'b0, 1'b0);
        tick(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick(4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        cancel = 1'b0;
        count_busy(n);
        chk("cancel_busy_rest", 32'(n), CANCEL_EN ? 32'd0 : 32'd2);
        chk("cancel_HI", HI, CANCEL_EN ? 32'h12345678 : 32'd1);
        chk("cancel_LO", LO, CANCEL_EN ? 32'hCAFEF00D : 32'd0);

        // async reset mid-div at cnt=4
        tick(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_HI", HI, 32'd0);
        chk("mid_rst_LO", LO, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_HI", HI, 32'd0);
        chk("post_rst_LO", LO, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
